// File: rtl/game_pkg.sv
// Shared screen-state encoding for the game sequencer and the overlay stages that decode state_out.
package game_pkg;

   localparam int ST_W = 2;

   localparam logic [ST_W-1:0] ST_START   = 2'b00;
   localparam logic [ST_W-1:0] ST_PLAY    = 2'b01;
   localparam logic [ST_W-1:0] ST_OVER    = 2'b10;
   localparam logic [ST_W-1:0] ST_ILLEGAL = 2'b11;

   typedef enum logic [ST_W-1:0] {
      S_START   = ST_START,
      S_PLAY    = ST_PLAY,
      S_OVER    = ST_OVER,
      S_ILLEGAL = ST_ILLEGAL
   } state_t;

endpackage

// File: rtl/edge_det.sv
// 1-bit rising-edge detector; the delay register resets to RST_VAL so a level
// already high at reset release can be kept from counting as an edge.
module edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) d_q <= RST_VAL;
      else     d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Screen sequencer START -> PLAY -> OVER, switching only on vblnk rising edges.
// Build option: define AUTO_RESTART_EN to leave OVER automatically after OVER_TIMEOUT frames.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int OVER_HOLD_FRAMES = 60,
   parameter int OVER_TIMEOUT     = 600,
   parameter int FCNT_W           = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn_start,
   input  logic            collision,
   input  logic            vblnk_in,
   output logic            start_en,
   output logic            game_en,
   output logic            over_en,
   output logic            game_rst,
   output logic [ST_W-1:0] state_out
);

   localparam int FCNT_NEED = (OVER_HOLD_FRAMES > OVER_TIMEOUT) ? OVER_HOLD_FRAMES : OVER_TIMEOUT;
   localparam logic [FCNT_W-1:0] HOLD_N = FCNT_W'(OVER_HOLD_FRAMES);

   if (FCNT_W < $clog2(FCNT_NEED + 1)) begin : g_fcnt_w_chk
      $error("game_state_ctrl: FCNT_W too narrow for OVER_HOLD_FRAMES/OVER_TIMEOUT");
   end

   state_t            state;
   state_t            state_nxt;
   logic              frame_tick;
   logic              btn_edge;
   logic              req_go;
   logic              req_die;
   logic              go;
   logic              die;
   logic              hold_ok;
   logic              timeout_hit;
   logic [FCNT_W-1:0] fcnt;

   edge_det #(.RST_VAL(1'b1)) u_vblnk_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (vblnk_in),
      .rise (frame_tick)
   );

   edge_det #(.RST_VAL(1'b0)) u_btn_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (btn_start),
      .rise (btn_edge)
   );

   // Requests include an event arriving on the tick cycle itself, so nothing is lost between frames.
   always_comb begin
      go      = req_go | btn_edge;
      die     = req_die | (collision & (state == S_PLAY));
      hold_ok = (fcnt >= HOLD_N);
`ifdef AUTO_RESTART_EN
      timeout_hit = (fcnt == FCNT_W'(OVER_TIMEOUT - 1));
`else
      timeout_hit = 1'b0;
`endif
      state_nxt = state;
      case (state)
         S_START: if (frame_tick && go)  state_nxt = S_PLAY;
         S_PLAY:  if (frame_tick && die) state_nxt = S_OVER;
         S_OVER:  if (frame_tick && ((go && hold_ok) || timeout_hit)) state_nxt = S_START;
         default: state_nxt = S_START;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_START;
         start_en <= 1'b1;
         game_en  <= 1'b0;
         over_en  <= 1'b0;
         game_rst <= 1'b0;
         req_go   <= 1'b0;
         req_die  <= 1'b0;
         fcnt     <= '0;
      end else begin
         state    <= state_nxt;
         start_en <= (state_nxt == S_START);
         game_en  <= (state_nxt == S_PLAY);
         over_en  <= (state_nxt == S_OVER);
         game_rst <= (state == S_START) && (state_nxt == S_PLAY);

         if (frame_tick || (state_nxt != state)) begin
            req_go  <= 1'b0;
            req_die <= 1'b0;
         end else begin
            req_go  <= go;
            req_die <= die;
         end

         // Counter is zero on entry to OVER and saturates rather than wrapping.
         if (state != S_OVER)
            fcnt <= '0;
         else if (frame_tick && (fcnt != '1))
            fcnt <= fcnt + 1'b1;
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized and directed bench for game_state_ctrl against a frame-level reference model.
module tb_game_state_ctrl;
   import game_pkg::*;

   localparam int HOLD = 4;
   localparam int TMO  = 8;
   localparam int FW   = 4;
`ifdef AUTO_RESTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            btn_start;
   logic            collision;
   logic            vblnk_in;
   logic            start_en;
   logic            game_en;
   logic            over_en;
   logic            game_rst;
   logic [ST_W-1:0] state_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: screen as 0=START 1=PLAY 2=OVER, pending requests, frames spent in OVER.
   int m_state;
   bit m_go, m_die, m_vbp, m_btnp, m_grst;
   int m_fcnt;

   game_state_ctrl #(
      .OVER_HOLD_FRAMES (HOLD),
      .OVER_TIMEOUT     (TMO),
      .FCNT_W           (FW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .collision (collision),
      .vblnk_in  (vblnk_in),
      .start_en  (start_en),
      .game_en   (game_en),
      .over_en   (over_en),
      .game_rst  (game_rst),
      .state_out (state_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".state"},    int'(state_out), m_state);
      check({tag, ".start_en"}, int'(start_en),  int'(m_state == 0));
      check({tag, ".game_en"},  int'(game_en),   int'(m_state == 1));
      check({tag, ".over_en"},  int'(over_en),   int'(m_state == 2));
      check({tag, ".game_rst"}, int'(game_rst),  int'(m_grst));
   endtask

   task automatic model_reset();
      m_state = 0;
      m_go    = 1'b0;
      m_die   = 1'b0;
      m_fcnt  = 0;
      m_vbp   = 1'b1;
      m_btnp  = 1'b0;
      m_grst  = 1'b0;
   endtask

   task automatic model_step(input bit b, input bit c, input bit v);
      bit tick, go, die;
      int nxt, nf;
      tick = v && !m_vbp;
      go   = m_go || (b && !m_btnp);
      die  = m_die || (c && m_state == 1);
      nxt  = m_state;
      nf   = m_fcnt;
      if (tick) begin
         if (m_state == 0 && go) nxt = 1;
         else if (m_state == 1 && die) nxt = 2;
         else if (m_state == 2) begin
            nf = (m_fcnt == (1 << FW) - 1) ? m_fcnt : m_fcnt + 1;
            if ((go && m_fcnt >= HOLD) || (AUTO && nf == TMO && m_fcnt < TMO)) nxt = 0;
         end
      end
      if (m_state != 2) nf = 0;
      if (tick || nxt != m_state) begin
         go  = 1'b0;
         die = 1'b0;
      end
      m_grst  = (m_state == 0 && nxt == 1);
      m_state = nxt;
      m_fcnt  = nf;
      m_go    = go;
      m_die   = die;
      m_vbp   = v;
      m_btnp  = b;
   endtask

   task automatic cycle(input bit b, input bit c, input bit v, input string tag);
      @(negedge clk);
      btn_start = b;
      collision = c;
      vblnk_in  = v;
      @(posedge clk);
      model_step(b, c, v);
      #1;
      check_outs(tag);
   endtask

   // One frame: some blank-low cycles with optional button/collision pulse, then the vblnk rise.
   task automatic frame(input bit b, input bit c, input string tag);
      cycle(1'b0, 1'b0, 1'b0, tag);
      cycle(b,    c,    1'b0, tag);
      cycle(1'b0, 1'b0, 1'b0, tag);
      cycle(1'b0, 1'b0, 1'b1, tag);
      cycle(1'b0, 1'b0, 1'b1, tag);
   endtask

   initial begin
      rst       = 1'b1;
      btn_start = 1'b0;
      collision = 1'b0;
      vblnk_in  = 1'b1;
      model_reset();

      // 1: reset held 5 clocks, released with vblnk high
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_outs("t1_rst");
      end
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b0, 1'b1, "t1_release");
      cycle(1'b0, 1'b0, 1'b1, "t1_release");

      // 2: button mid-frame, nothing changes until the tick, then PLAY with one game_rst
      cycle(1'b0, 1'b0, 1'b0, "t2");
      cycle(1'b1, 1'b0, 1'b0, "t2");
      cycle(1'b1, 1'b0, 1'b0, "t2");
      cycle(1'b0, 1'b0, 1'b0, "t2");
      cycle(1'b0, 1'b0, 1'b1, "t2_tick");
      check("t2_play", int'(state_out), int'(ST_PLAY));
      cycle(1'b0, 1'b0, 1'b1, "t2_after");
      check("t2_grst_gone", int'(game_rst), 0);

      // 3: collision and button together in PLAY -> OVER, no game_rst
      frame(1'b1, 1'b1, "t3");
      check("t3_over", int'(state_out), int'(ST_OVER));

      // 4: presses during the hold window are dropped, first press after it is accepted
      for (int k = 1; k <= HOLD; k++) frame(1'b1, 1'b0, "t4_hold");
      check("t4_still_over", int'(state_out), int'(ST_OVER));
      frame(1'b1, 1'b0, "t4_accept");
      check("t4_start", int'(state_out), int'(ST_START));

      // 5: idle in OVER (auto restart with the macro, stays put without it)
      frame(1'b1, 1'b0, "t5_go");
      frame(1'b0, 1'b1, "t5_die");
      for (int k = 1; k <= 20; k++) frame(1'b0, 1'b0, "t5_idle");
      check("t5_end", int'(state_out), AUTO ? int'(ST_START) : int'(ST_OVER));
      frame(1'b1, 1'b0, "t5_btn");
      if (m_state != 1) frame(1'b1, 1'b0, "t5_btn2");

      // 6a: illegal encoding recovers to START on the next clock
      check("t6_in_play", int'(state_out), int'(ST_PLAY));
      @(negedge clk);
      force dut.state = S_ILLEGAL;
      #1;
      release dut.state;
      check("t6_forced", int'(state_out), int'(ST_ILLEGAL));
      @(posedge clk);
      m_state = 0;
      m_go    = 1'b0;
      m_die   = 1'b0;
      m_grst  = 1'b0;
      m_fcnt  = 0;
      #1;
      check_outs("t6_recover");

      // 6b: reset asserted mid-frame in PLAY, takes effect without a clock
      frame(1'b1, 1'b0, "t6_go");
      cycle(1'b0, 1'b0, 1'b0, "t6_mid");
      @(negedge clk);
      rst      = 1'b1;
      vblnk_in = 1'b1;
      model_reset();
      #1;
      check_outs("t6_async_rst");
      @(posedge clk);
      #1;
      check_outs("t6_rst_hold");
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 1'b0, 1'b1, "t6_no_tick");
      cycle(1'b0, 1'b0, 1'b0, "t6_low");
      cycle(1'b0, 1'b0, 1'b1, "t6_real_tick");

      // Randomized frames
      for (int f = 0; f < 300; f++) begin
         int lo, hi;
         lo = int'($urandom_range(3, 10));
         hi = int'($urandom_range(1, 4));
         for (int i = 0; i < lo + hi; i++) begin
            bit b, c;
            b = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 7) == 0);
            cycle(b, c, (i >= lo), "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
